// File: rtl/shift_issue_if.sv
// Handshake and payload bundle between issue logic and the shift stage.
// Master drives requests and write-back; slave returns the head entry.
interface shift_issue_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [5:0]  funct_i;
    logic [4:0]  shamt_i;
    logic [4:0]  rs_idx_i;
    logic [4:0]  rt_idx_i;
    logic [4:0]  rd_idx_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        fwd_we_i;
    logic [4:0]  fwd_idx_i;
    logic [31:0] fwd_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] A_o;
    logic [31:0] B_o;
    logic [3:0]  Operation_o;
    logic [4:0]  rd_idx_o;
    logic        illegal_o;

    modport master (
        output in_valid_i, funct_i, shamt_i,
        output rs_idx_i, rt_idx_i, rd_idx_i,
        output rs_data_i, rt_data_i,
        output fwd_we_i, fwd_idx_i, fwd_data_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o,
        input  A_o, B_o, Operation_o,
        input  rd_idx_o, illegal_o
    );

    modport slave (
        input  in_valid_i, funct_i, shamt_i,
        input  rs_idx_i, rt_idx_i, rd_idx_i,
        input  rs_data_i, rt_data_i,
        input  fwd_we_i, fwd_idx_i, fwd_data_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o,
        output A_o, B_o, Operation_o,
        output rd_idx_o, illegal_o
    );
endinterface

// File: rtl/shift_issue_stage.sv
// Shift-unit issue stage: funct decode, operand select and a
// 2-entry skid buffer whose register operands snoop write-back.
module shift_issue_stage #(
    parameter logic [3:0] OP_SLL  = 4'b1000,
    parameter logic [3:0] OP_SRL  = 4'b1010,
    parameter logic [3:0] OP_SRA  = 4'b1011,
    parameter logic [3:0] OP_PASS = 4'b0000
) (
    input logic         clk_i,
    input logic         rst_ni,
    input logic         flush_i,
    shift_issue_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  a_idx;
        logic [4:0]  b_idx;
        logic        b_reg;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } slot_t;

    state_t state_q, state_d;
    slot_t  head_q, head_d;
    slot_t  skid_q, skid_d;
    slot_t  cap, head_snp, skid_snp;
    logic   ready_q;
    logic   accept, pop;

    function automatic logic [31:0] pick(
        input logic [4:0]  idx,
        input logic [31:0] data,
        input logic        we,
        input logic [4:0]  fidx,
        input logic [31:0] fdata
    );
        if (idx == 5'd0)
            return 32'd0;
        if (we && fidx == idx)
            return fdata;
        return data;
    endfunction

    function automatic slot_t snoop(
        input slot_t       s,
        input logic        we,
        input logic [4:0]  fidx,
        input logic [31:0] fdata
    );
        slot_t r;
        r = s;
        if (we && fidx != 5'd0) begin
            if (s.a_idx == fidx)
                r.a = fdata;
            if (s.b_reg && s.b_idx == fidx)
                r.b = fdata;
        end
        return r;
    endfunction

    assign accept = bus.in_valid_i & ready_q;
    assign pop    = (state_q != EMPTY) & bus.out_ready_i;

    assign head_snp = snoop(head_q, bus.fwd_we_i,
                            bus.fwd_idx_i, bus.fwd_data_i);
    assign skid_snp = snoop(skid_q, bus.fwd_we_i,
                            bus.fwd_idx_i, bus.fwd_data_i);

    // Decode the incoming funct and build the entry to capture.
    always_comb begin
        cap       = '0;
        cap.a     = pick(bus.rt_idx_i, bus.rt_data_i, bus.fwd_we_i,
                         bus.fwd_idx_i, bus.fwd_data_i);
        cap.a_idx = bus.rt_idx_i;
        cap.rd    = bus.rd_idx_i;
        unique case (bus.funct_i)
            6'b000000: begin
                cap.op = OP_SLL;
                cap.b  = {27'b0, bus.shamt_i};
            end
            6'b000010: begin
                cap.op = OP_SRL;
                cap.b  = {27'b0, bus.shamt_i};
            end
            6'b000011: begin
                cap.op = OP_SRA;
                cap.b  = {27'b0, bus.shamt_i};
            end
            6'b000100, 6'b000110, 6'b000111: begin
                unique case (bus.funct_i[1:0])
                    2'b00:   cap.op = OP_SLL;
                    2'b10:   cap.op = OP_SRL;
                    default: cap.op = OP_SRA;
                endcase
                cap.b     = pick(bus.rs_idx_i, bus.rs_data_i,
                                 bus.fwd_we_i, bus.fwd_idx_i,
                                 bus.fwd_data_i);
                cap.b_idx = bus.rs_idx_i;
                cap.b_reg = 1'b1;
            end
            default: begin
                cap.op  = OP_PASS;
                cap.ill = 1'b1;
            end
        endcase
    end

    // Skid-buffer next state; flush wins, stored entries snoop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        head_d  = cap;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = cap;
                    end else if (accept) begin
                        state_d = TWO;
                        head_d  = head_snp;
                        skid_d  = cap;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end else begin
                        head_d = head_snp;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = skid_snp;
                    end else begin
                        head_d = head_snp;
                        skid_d = skid_snp;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, slot storage and registered ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != TWO);
        end
    end

    assign bus.in_ready_o  = ready_q;
    assign bus.out_valid_o = (state_q != EMPTY);
    assign bus.A_o         = head_q.a;
    assign bus.B_o         = head_q.b;
    assign bus.Operation_o = head_q.op;
    assign bus.rd_idx_o    = head_q.rd;
    assign bus.illegal_o   = head_q.ill;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_shift_issue_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
        logic [4:0]  a_src;
        logic [4:0]  b_src;
        logic        b_is_reg;
    } exp_t;

    logic clk;
    logic rst_ni;
    logic flush;

    shift_issue_if sif ();

    shift_issue_stage dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .flush_i(flush),
        .bus    (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors;
    int          checks;
    logic [31:0] regs [32];
    exp_t        q[$];
    exp_t        cur;
    logic        mdl_ready;

    function automatic logic [31:0] src_val(input logic [4:0] idx,
                                            input logic [31:0] d);
        if (idx == 0) return 32'd0;
        if (sif.fwd_we_i && sif.fwd_idx_i == idx) return sif.fwd_data_i;
        return d;
    endfunction

    function automatic exp_t model_capture();
        exp_t e;
        e = '{default: '0};
        e.a     = src_val(sif.rt_idx_i, sif.rt_data_i);
        e.a_src = sif.rt_idx_i;
        e.rd    = sif.rd_idx_i;
        case (sif.funct_i)
            6'd0, 6'd4: e.op = 4'b1000;
            6'd2, 6'd6: e.op = 4'b1010;
            6'd3, 6'd7: e.op = 4'b1011;
            default: begin
                e.op  = 4'b0000;
                e.ill = 1'b1;
            end
        endcase
        if (sif.funct_i == 6'd0 || sif.funct_i == 6'd2 ||
            sif.funct_i == 6'd3)
            e.b = {27'd0, sif.shamt_i};
        if (sif.funct_i == 6'd4 || sif.funct_i == 6'd6 ||
            sif.funct_i == 6'd7) begin
            e.b        = src_val(sif.rs_idx_i, sif.rs_data_i);
            e.b_src    = sif.rs_idx_i;
            e.b_is_reg = 1'b1;
        end
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        cur       = '{default: '0};
        mdl_ready = 1'b1;
    endtask

    task automatic step();
        logic acc, pp;
        exp_t e;
        @(posedge clk);
        acc = sif.in_valid_i && mdl_ready;
        pp  = (q.size() > 0) && sif.out_ready_i;
        e   = model_capture();
        if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (sif.fwd_we_i && sif.fwd_idx_i != 0)
                foreach (q[i]) begin
                    if (q[i].a_src == sif.fwd_idx_i)
                        q[i].a = sif.fwd_data_i;
                    if (q[i].b_is_reg && q[i].b_src == sif.fwd_idx_i)
                        q[i].b = sif.fwd_data_i;
                end
            if (acc) q.push_back(e);
        end
        if (sif.fwd_we_i && sif.fwd_idx_i != 0)
            regs[sif.fwd_idx_i] = sif.fwd_data_i;
        mdl_ready = (q.size() < 2);
        if (q.size() > 0) cur = q[0];
        @(negedge clk);
    endtask

    task automatic drive_op(input logic [5:0] f, input logic [4:0] sh,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd);
        sif.in_valid_i = 1'b1;
        sif.funct_i    = f;
        sif.shamt_i    = sh;
        sif.rs_idx_i   = rs;
        sif.rt_idx_i   = rt;
        sif.rd_idx_i   = rd;
        sif.rs_data_i  = regs[rs];
        sif.rt_data_i  = regs[rt];
    endtask

    task automatic idle();
        sif.in_valid_i = 1'b0;
        sif.fwd_we_i   = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic test_reset();
        if (sif.out_valid_o !== 1'b0 || sif.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs got v=%b r=%b want v=0 r=1",
                     sif.out_valid_o, sif.in_ready_o);
        end
        checks++;
        if ({sif.A_o, sif.B_o, sif.Operation_o, sif.rd_idx_o,
             sif.illegal_o} !== '0) begin
            errors++;
            $display("FAIL reset_payload got A=%h B=%h op=%h",
                     sif.A_o, sif.B_o, sif.Operation_o);
        end
        checks++;
    endtask

    task automatic test_sll();
        regs[2] = 32'h0000_00F0;
        sif.out_ready_i = 1'b1;
        drive_op(6'b000000, 5'd4, 5'd0, 5'd2, 5'd7);
        step();
        if (sif.out_valid_o !== 1'b1 || sif.A_o !== 32'hF0 ||
            sif.B_o !== 32'd4 || sif.Operation_o !== 4'b1000) begin
            errors++;
            $display("FAIL sll got v=%b A=%h B=%h op=%b want 1 f0 4 1000",
                     sif.out_valid_o, sif.A_o, sif.B_o, sif.Operation_o);
        end
        checks++;
        idle();
        step();
        if (sif.out_valid_o !== 1'b0 || sif.A_o !== 32'hF0) begin
            errors++;
            $display("FAIL empty_hold got v=%b A=%h want 0 f0",
                     sif.out_valid_o, sif.A_o);
        end
        checks++;
    endtask

    task automatic test_fwd_capture();
        regs[3] = 32'd5;
        regs[4] = 32'h8000_0000;
        drive_op(6'b000111, 5'd0, 5'd3, 5'd4, 5'd1);
        sif.fwd_we_i   = 1'b1;
        sif.fwd_idx_i  = 5'd3;
        sif.fwd_data_i = 32'h1F;
        step();
        if (sif.B_o !== 32'h1F || sif.Operation_o !== 4'b1011 ||
            sif.A_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL srav_fwd got A=%h B=%h op=%b want 80000000 1f 1011",
                     sif.A_o, sif.B_o, sif.Operation_o);
        end
        checks++;
        idle();
        step();
    endtask

    task automatic test_stall_order();
        regs[10] = 32'h10;
        regs[11] = 32'h11;
        regs[12] = 32'h12;
        sif.out_ready_i = 1'b0;
        drive_op(6'd0, 5'd1, 5'd0, 5'd10, 5'd10);
        step();
        if (sif.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_one got %b want 1", sif.in_ready_o);
        end
        checks++;
        drive_op(6'd0, 5'd1, 5'd0, 5'd11, 5'd11);
        step();
        if (sif.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_two got %b want 0", sif.in_ready_o);
        end
        checks++;
        drive_op(6'd0, 5'd1, 5'd0, 5'd12, 5'd12);
        step();
        if (sif.A_o !== 32'h10 || sif.rd_idx_o !== 5'd10) begin
            errors++;
            $display("FAIL stall_hold got A=%h rd=%0d want 10 10",
                     sif.A_o, sif.rd_idx_o);
        end
        checks++;
        idle();
        sif.out_ready_i = 1'b1;
        step();
        if (sif.out_valid_o !== 1'b1 || sif.A_o !== 32'h11) begin
            errors++;
            $display("FAIL order_2nd got v=%b A=%h want 1 11",
                     sif.out_valid_o, sif.A_o);
        end
        checks++;
        step();
        if (sif.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drained got v=%b want 0", sif.out_valid_o);
        end
        checks++;
    endtask

    task automatic test_snoop();
        regs[5] = 32'd1;
        regs[6] = 32'h100;
        sif.out_ready_i = 1'b0;
        drive_op(6'b000110, 5'd0, 5'd5, 5'd6, 5'd2);
        step();
        drive_op(6'b000000, 5'd3, 5'd0, 5'd5, 5'd3);
        step();
        idle();
        sif.fwd_we_i   = 1'b1;
        sif.fwd_idx_i  = 5'd5;
        sif.fwd_data_i = 32'd7;
        step();
        if (sif.B_o !== 32'd7 || sif.A_o !== 32'h100) begin
            errors++;
            $display("FAIL snoop_b got A=%h B=%h want 100 7",
                     sif.A_o, sif.B_o);
        end
        checks++;
        sif.fwd_idx_i  = 5'd0;
        sif.fwd_data_i = 32'hDEAD;
        step();
        if (sif.B_o !== 32'd7 || sif.A_o !== 32'h100) begin
            errors++;
            $display("FAIL snoop_r0 got A=%h B=%h want 100 7",
                     sif.A_o, sif.B_o);
        end
        checks++;
        idle();
        sif.out_ready_i = 1'b1;
        step();
        if (sif.A_o !== 32'd7 || sif.B_o !== 32'd3) begin
            errors++;
            $display("FAIL snoop_imm got A=%h B=%h want 7 3",
                     sif.A_o, sif.B_o);
        end
        checks++;
        step();
    endtask

    task automatic test_illegal_flush();
        regs[2] = 32'h55;
        sif.out_ready_i = 1'b0;
        drive_op(6'b100000, 5'd9, 5'd1, 5'd2, 5'd9);
        step();
        if (sif.illegal_o !== 1'b1 || sif.Operation_o !== 4'd0 ||
            sif.B_o !== 32'd0 || sif.A_o !== 32'h55 ||
            sif.rd_idx_o !== 5'd9) begin
            errors++;
            $display("FAIL illegal got ill=%b op=%h B=%h A=%h rd=%0d",
                     sif.illegal_o, sif.Operation_o, sif.B_o, sif.A_o,
                     sif.rd_idx_o);
        end
        checks++;
        drive_op(6'd0, 5'd2, 5'd0, 5'd2, 5'd4);
        step();
        flush = 1'b1;
        drive_op(6'd2, 5'd2, 5'd0, 5'd2, 5'd5);
        step();
        if (sif.out_valid_o !== 1'b0 || sif.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush got v=%b r=%b want 0 1",
                     sif.out_valid_o, sif.in_ready_o);
        end
        checks++;
        idle();
        step();
        if (sif.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got v=%b want 0", sif.out_valid_o);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [5:0] ftab [8];
        ftab = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd32, 6'd5};
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(3) != 0)
                drive_op(ftab[$urandom_range(7)], 5'($urandom),
                         5'($urandom_range(7)), 5'($urandom_range(7)),
                         5'($urandom));
            sif.out_ready_i = ($urandom_range(2) != 0);
            sif.fwd_we_i    = ($urandom_range(1) != 0);
            sif.fwd_idx_i   = 5'($urandom_range(7));
            sif.fwd_data_i  = $urandom;
            flush           = ($urandom_range(24) == 0);
            step();
            if (sif.out_valid_o !== (q.size() > 0) ||
                sif.in_ready_o !== mdl_ready) begin
                errors++;
                $display("FAIL rnd_hs cyc %0d got v=%b r=%b want %b %b",
                         n, sif.out_valid_o, sif.in_ready_o,
                         q.size() > 0, mdl_ready);
            end
            checks++;
            if (sif.A_o !== cur.a || sif.B_o !== cur.b) begin
                errors++;
                $display("FAIL rnd_ab cyc %0d got %h %h want %h %h",
                         n, sif.A_o, sif.B_o, cur.a, cur.b);
            end
            checks++;
            if (sif.Operation_o !== cur.op || sif.rd_idx_o !== cur.rd ||
                sif.illegal_o !== cur.ill) begin
                errors++;
                $display("FAIL rnd_op cyc %0d got %h %0d %b want %h %0d %b",
                         n, sif.Operation_o, sif.rd_idx_o, sif.illegal_o,
                         cur.op, cur.rd, cur.ill);
            end
            checks++;
        end
        idle();
    endtask

    task automatic test_async_reset();
        sif.out_ready_i = 1'b0;
        drive_op(6'd0, 5'd1, 5'd0, 5'd2, 5'd6);
        step();
        drive_op(6'd4, 5'd0, 5'd3, 5'd4, 5'd7);
        step();
        idle();
        #2;
        rst_ni = 1'b0;
        #1;
        if (sif.out_valid_o !== 1'b0 || sif.in_ready_o !== 1'b1 ||
            {sif.A_o, sif.B_o, sif.Operation_o, sif.rd_idx_o,
             sif.illegal_o} !== '0) begin
            errors++;
            $display("FAIL async_rst got v=%b r=%b A=%h B=%h op=%h",
                     sif.out_valid_o, sif.in_ready_o, sif.A_o, sif.B_o,
                     sif.Operation_o);
        end
        checks++;
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        if (sif.out_valid_o !== 1'b0 || sif.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL post_rst got v=%b r=%b want 0 1",
                     sif.out_valid_o, sif.in_ready_o);
        end
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_ni = 1'b0;
        flush  = 1'b0;
        sif.in_valid_i  = 1'b0;
        sif.funct_i     = '0;
        sif.shamt_i     = '0;
        sif.rs_idx_i    = '0;
        sif.rt_idx_i    = '0;
        sif.rd_idx_i    = '0;
        sif.rs_data_i   = '0;
        sif.rt_data_i   = '0;
        sif.fwd_we_i    = 1'b0;
        sif.fwd_idx_i   = '0;
        sif.fwd_data_i  = '0;
        sif.out_ready_i = 1'b0;
        foreach (regs[i]) regs[i] = $urandom;
        regs[0] = 32'hBAD0_0000;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst_ni = 1'b1;
        @(negedge clk);
        test_sll();
        test_fwd_capture();
        test_stall_order();
        test_snoop();
        test_illegal_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
